// File: rtl/lcd_byte_writer.sv
// HD44780 write-only bus timing engine: one byte + RS per start request, with setup,
// enable pulse, hold and command execution wait, then a single-cycle done pulse.
module lcd_byte_writer #(
    parameter int SETUP_CYC     = 4,
    parameter int EN_HIGH_CYC   = 12,
    parameter int HOLD_CYC      = 4,
    parameter int CMD_WAIT_CYC  = 2000,
    parameter int LONG_WAIT_CYC = 82000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       rs_in,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       byte_r, byte_s;
    logic             rs_r, rs_s;
    logic             en_r, en_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             long_wait_s;
    logic [CNT_W-1:0] wait_ld_s;

    // Clear and Return Home need the long execution time; everything else uses the short one.
    always_comb begin
        long_wait_s = (rs_r == 1'b0) &&
                      ((byte_r == 8'h01) || (byte_r == 8'h02) || (byte_r == 8'h03));
        if (long_wait_s) begin
            wait_ld_s = LONG_LD;
        end else begin
            wait_ld_s = CMD_LD;
        end
    end

    // Next-state, counter and registered-output values for the bus sequence.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        byte_s  = byte_r;
        rs_s    = rs_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    byte_s  = data_in;
                    rs_s    = rs_in;
                    cnt_s   = SETUP_LD;
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == CNT_ZERO) begin
                    cnt_s   = EN_LD;
                    state_s = PULSE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    cnt_s   = HOLD_LD;
                    state_s = HOLD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_r == CNT_ZERO) begin
                    cnt_s   = wait_ld_s;
                    state_s = WAIT;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                cnt_s   = CNT_ZERO;
                state_s = IDLE;
            end
        endcase
        // EN and busy are derived from the next state so their registers line up with the phases.
        en_s   = (state_s == PULSE);
        busy_s = (state_s != IDLE);
    end

    // State, counter, latched byte and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            byte_r  <= 8'h00;
            rs_r    <= 1'b0;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            byte_r  <= byte_s;
            rs_r    <= rs_s;
            en_r    <= en_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign LCD_DATA = byte_r;
    assign LCD_RS   = rs_r;
    assign LCD_EN   = en_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer with shortened execution waits:
// normal latency 1+4+12+4+200 = 221 cycles, Clear/Home latency 1+4+12+4+1000 = 1021 cycles.
module tb_lcd_byte_writer;

    localparam int LAT_N = 221;
    localparam int LAT_L = 1021;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       rs_in;
    logic       start;
    logic       done;
    logic       busy;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_ON;
    logic       LCD_BLON;

    int total = 0;
    int bad   = 0;

    int w_done_n, w_done_cnt, w_en_first, w_en_last, w_en_cnt;
    int w_busy_first, w_busy_last, w_busy_cnt, w_bus_bad;
    logic       en_prev;
    logic [8:0] cap[$];
    logic [7:0] seq_d[34];
    logic       seq_r[34];

    lcd_byte_writer #(
        .SETUP_CYC(4), .EN_HIGH_CYC(12), .HOLD_CYC(4),
        .CMD_WAIT_CYC(200), .LONG_WAIT_CYC(1000), .CNT_W(20)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .rs_in(rs_in), .start(start),
        .done(done), .busy(busy), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, int'(LCD_DATA), 0);
        chk({tag, "_rs"},   int'(LCD_RS), 0);
        chk({tag, "_en"},   int'(LCD_EN), 0);
        chk({tag, "_rw"},   int'(LCD_RW), 0);
        chk({tag, "_on"},   int'(LCD_ON), 1);
        chk({tag, "_blon"}, int'(LCD_BLON), 1);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Present a start pulse; now=1 means we are already at the negedge of the previous done cycle.
    task automatic do_start(input logic [7:0] d, input logic r, input bit now);
        if (!now) @(negedge clk);
        data_in = d;
        rs_in   = r;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Observe up to max cycles after the start edge (cycle n sampled at its negedge).
    task automatic watch(input int max, input bit stop_on_done, input bit glitch,
                         input logic [7:0] exp_d, input logic exp_r);
        w_done_n = 0; w_done_cnt = 0; w_en_first = 0; w_en_last = 0; w_en_cnt = 0;
        w_busy_first = 0; w_busy_last = 0; w_busy_cnt = 0; w_bus_bad = 0;
        en_prev = 1'b0;
        for (int n = 1; n <= max; n++) begin
            @(negedge clk);
            if (glitch) begin
                start   = (n == 3) || (n == 10) || (n == 100);
                data_in = 8'hFF;
                rs_in   = 1'b0;
            end
            if (LCD_EN) begin
                w_en_cnt++;
                if (w_en_first == 0) w_en_first = n;
                w_en_last = n;
                if (!en_prev) cap.push_back({LCD_RS, LCD_DATA});
            end
            en_prev = LCD_EN;
            if (busy) begin
                w_busy_cnt++;
                if (w_busy_first == 0) w_busy_first = n;
                w_busy_last = n;
            end
            if ((LCD_DATA !== exp_d) || (LCD_RS !== exp_r)) w_bus_bad++;
            if (done) begin
                w_done_cnt++;
                if (w_done_n == 0) w_done_n = n;
                if (stop_on_done) break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        reset = 1'b1; start = 1'b0; data_in = 8'h00; rs_in = 1'b0;
        #2;
        chk_reset_vals("t1_por");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single data write 0x41: timing of bus, EN, busy and done.
        do_start(8'h41, 1'b1, 1'b0);
        watch(LAT_N + 10, 1'b0, 1'b0, 8'h41, 1'b1);
        chk("t2_done_n", w_done_n, LAT_N);
        chk("t2_done_cnt", w_done_cnt, 1);
        chk("t2_en_first", w_en_first, 5);
        chk("t2_en_last", w_en_last, 16);
        chk("t2_en_cnt", w_en_cnt, 12);
        chk("t2_busy_first", w_busy_first, 1);
        chk("t2_busy_last", w_busy_last, LAT_N - 1);
        chk("t2_busy_cnt", w_busy_cnt, LAT_N - 1);
        chk("t2_bus_bad", w_bus_bad, 0);
        chk("t2_idle_keep", int'(LCD_DATA), 'h41);

        // Reset asserted while idle with a non-zero bus.
        @(negedge clk);
        reset = 1'b1;
        #1 chk_reset_vals("t1_idle");
        @(negedge clk);
        reset = 1'b0;

        // Long wait only for rs=0 bytes 0x01..0x03.
        do_start(8'h01, 1'b0, 1'b0);
        watch(LAT_L + 5, 1'b1, 1'b0, 8'h01, 1'b0);
        chk("t3_clear", w_done_n, LAT_L);
        do_start(8'h02, 1'b0, 1'b0);
        watch(LAT_L + 5, 1'b1, 1'b0, 8'h02, 1'b0);
        chk("t3_home", w_done_n, LAT_L);
        do_start(8'h38, 1'b0, 1'b0);
        watch(LAT_L + 5, 1'b1, 1'b0, 8'h38, 1'b0);
        chk("t3_func", w_done_n, LAT_N);
        do_start(8'hC0, 1'b0, 1'b0);
        watch(LAT_L + 5, 1'b1, 1'b0, 8'hC0, 1'b0);
        chk("t3_ddram", w_done_n, LAT_N);
        do_start(8'h01, 1'b1, 1'b0);
        watch(LAT_L + 5, 1'b1, 1'b0, 8'h01, 1'b1);
        chk("t3_data01", w_done_n, LAT_N);

        // Extra start pulses with 0xFF while busy are ignored and not queued.
        do_start(8'h41, 1'b1, 1'b0);
        watch(LAT_N + 150, 1'b0, 1'b1, 8'h41, 1'b1);
        chk("t4_done_n", w_done_n, LAT_N);
        chk("t4_done_cnt", w_done_cnt, 1);
        chk("t4_en_cnt", w_en_cnt, 12);
        chk("t4_bus_bad", w_bus_bad, 0);

        // Sequencer model: back-to-back writes, each start issued in the done cycle.
        seq_d[0] = 8'h02; seq_r[0] = 1'b0;
        seq_d[17] = 8'hC0; seq_r[17] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            seq_d[1 + i]  = 8'h41 + 8'(i); seq_r[1 + i]  = 1'b1;
            seq_d[18 + i] = 8'h61 + 8'(i); seq_r[18 + i] = 1'b1;
        end
        cap.delete();
        begin
            int n_done;
            int lat_bad;
            n_done = 0; lat_bad = 0;
            for (int i = 0; i < 34; i++) begin
                do_start(seq_d[i], seq_r[i], i > 0);
                watch(LAT_L + 5, 1'b1, 1'b0, seq_d[i], seq_r[i]);
                n_done += w_done_cnt;
                lat = (i == 0) ? LAT_L : LAT_N;
                if (w_done_n != lat) lat_bad++;
            end
            chk("t5_done_cnt", n_done, 34);
            chk("t5_lat_bad", lat_bad, 0);
            chk("t5_en_pulses", cap.size(), 34);
            for (int i = 0; i < 34; i++) begin
                chk($sformatf("t5_bus%0d", i),
                    (i < cap.size()) ? int'(cap[i]) : -1, int'({seq_r[i], seq_d[i]}));
            end
        end

        // Reset during the enable pulse aborts the write; a fresh write then completes.
        do_start(8'h41, 1'b1, 1'b0);
        watch(8, 1'b0, 1'b0, 8'h41, 1'b1);
        chk("t6_en_before", int'(LCD_EN), 1);
        reset = 1'b1;
        #1 chk_reset_vals("t6_rst");
        @(negedge clk);
        reset = 1'b0;
        watch(LAT_N + 20, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("t6_no_done", w_done_cnt, 0);
        chk("t6_no_en", w_en_cnt, 0);
        do_start(8'h38, 1'b0, 1'b0);
        watch(LAT_N + 5, 1'b1, 1'b0, 8'h38, 1'b0);
        chk("t6_restart", w_done_n, LAT_N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
